// File: rtl/fp_addsub_seq_if.sv
// Request/response bundle for the sequential FP add/sub engine.
// The master drives operands and start; the slave returns status and result.
interface fp_addsub_seq_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [2:0]   flags;

  modport master (output start, op, x, y, input  busy, done, result, flags);
  modport slave  (input  start, op, x, y, output busy, done, result, flags);
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle parametrised floating-point adder/subtractor with RNE rounding.
// One operation in flight; subnormals are flushed to zero.
module fp_addsub_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  fp_addsub_seq_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 5;   // carry | hidden | frac | G R S
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0]    EMAX    = '1;
  localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  state_t                 r_state, w_next;
  logic [W-1:0]           r_x, r_y, r_aw, r_res;
  logic [2:0]             r_flags;
  logic                   r_sa, r_sb;
  logic signed [XW-1:0]   r_exp;
  logic [EXP_W-1:0]       r_d;
  logic [SW-1:0]          r_ma, r_mb;
  logic                   r_nan, r_inv, r_inf, r_zz;

  // Order operands by magnitude so the subtract in ADD can never go negative.
  logic                   w_swap;
  logic [W-1:0]           w_a, w_b;
  logic [EXP_W-1:0]       w_ea, w_eb;
  logic [MAN_W-1:0]       w_fa, w_fb;
  logic                   w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic                   w_special;
  logic [SW-1:0]          w_sum;
  logic                   w_up;
  logic [MAN_W+1:0]       w_rnd;

  assign w_swap = r_y[W-2:0] > r_x[W-2:0];
  assign w_a    = w_swap ? r_y : r_x;
  assign w_b    = w_swap ? r_x : r_y;
  assign w_ea   = w_a[W-2:MAN_W];
  assign w_eb   = w_b[W-2:MAN_W];
  assign w_fa   = w_a[MAN_W-1:0];
  assign w_fb   = w_b[MAN_W-1:0];

  assign w_nan_a  = (w_ea == EMAX) && (w_fa != '0);
  assign w_nan_b  = (w_eb == EMAX) && (w_fb != '0);
  assign w_inf_a  = (w_ea == EMAX) && (w_fa == '0);
  assign w_inf_b  = (w_eb == EMAX) && (w_fb == '0);
  assign w_zero_a = (w_ea == '0);
  assign w_zero_b = (w_eb == '0);
  assign w_special = w_nan_a | w_nan_b | w_inf_a | w_inf_b | w_zero_a | w_zero_b;

  assign w_sum = (r_sa == r_sb) ? r_ma + r_mb : r_ma - r_mb;
  assign w_up  = r_ma[2] & (r_ma[1] | r_ma[0] | r_ma[3]);
  assign w_rnd = {1'b0, r_ma[SW-2:3]} + {{(MAN_W+1){1'b0}}, w_up};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = S_UNPACK;
      S_UNPACK:  w_next = w_special ? S_SPECIAL : S_ALIGN;
      S_SPECIAL: w_next = S_DONE;
      S_ALIGN:   if (r_d == '0) w_next = S_ADD;
      S_ADD:     w_next = (w_sum == '0) ? S_DONE : S_NORM;
      S_NORM:    if (r_ma[SW-1] || r_ma[SW-2]) w_next = S_ROUND;
      S_ROUND:   w_next = S_PACK;
      S_PACK:    w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_aw    <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_exp   <= '0;
      r_d     <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_nan   <= 1'b0;
      r_inv   <= 1'b0;
      r_inf   <= 1'b0;
      r_zz    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_x <= bus.x;
          r_y <= {bus.y[W-1] ^ bus.op, bus.y[W-2:0]};
        end
        S_UNPACK: begin
          r_sa  <= w_a[W-1];
          r_sb  <= w_b[W-1];
          r_exp <= $signed({2'b00, w_ea});
          r_d   <= w_ea - w_eb;
          r_ma  <= {2'b01, w_fa, 3'b000};
          r_mb  <= {2'b01, w_fb, 3'b000};
          r_inv <= w_inf_a & w_inf_b & (w_a[W-1] != w_b[W-1]);
          r_nan <= w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_a[W-1] != w_b[W-1]));
          r_inf <= w_inf_a;
          r_zz  <= w_zero_a & w_zero_b;
          r_aw  <= w_a;
        end
        S_SPECIAL: begin
          r_flags <= {r_inv, 2'b00};
          if (r_nan)      r_res <= QNAN;
          else if (r_inf) r_res <= {r_aw[W-1], EMAX, {MAN_W{1'b0}}};
          else if (r_zz)  r_res <= {r_sa & r_sb, {(W-1){1'b0}}};
          else            r_res <= r_aw;
        end
        S_ALIGN: if (r_d != '0) begin
          // Far-apart operands: only the sticky contribution of B survives.
          if (int'(r_d) > MAN_W + 3) begin
            r_mb <= {{(SW-1){1'b0}}, |r_mb};
            r_d  <= '0;
          end else begin
            r_mb <= {1'b0, r_mb[SW-1:2], r_mb[1] | r_mb[0]};
            r_d  <= r_d - 1'b1;
          end
        end
        S_ADD: begin
          if (w_sum == '0) begin
            r_res   <= '0;
            r_flags <= '0;
          end else begin
            r_ma <= w_sum;
          end
        end
        S_NORM: begin
          if (r_ma[SW-1]) begin
            r_ma  <= {1'b0, r_ma[SW-1:2], r_ma[1] | r_ma[0]};
            r_exp <= r_exp + XW'(1);
          end else if (!r_ma[SW-2]) begin
            r_ma  <= {r_ma[SW-2:0], 1'b0};
            r_exp <= r_exp - XW'(1);
          end
        end
        S_ROUND: begin
          if (w_rnd[MAN_W+1]) begin
            r_ma  <= {1'b0, w_rnd[MAN_W+1:1], 3'b000};
            r_exp <= r_exp + XW'(1);
          end else begin
            r_ma  <= {w_rnd, 3'b000};
          end
        end
        S_PACK: begin
          if (r_exp >= EXP_TOP) begin
            r_res   <= {r_sa, EMAX, {MAN_W{1'b0}}};
            r_flags <= 3'b010;
          end else if (r_exp < XW'(1)) begin
            r_res   <= {r_sa, {(W-1){1'b0}}};
            r_flags <= 3'b001;
          end else begin
            r_res   <= {r_sa, r_exp[EXP_W-1:0], r_ma[SW-3:3]};
            r_flags <= 3'b000;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_res;
  assign bus.flags  = r_flags;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: half-precision vectors plus one single-precision case.
module tb_fp_addsub_seq;
  logic clk, reset;
  int   n_chk, n_fail;

  fp_addsub_seq_if #(.EXP_W(5), .MAN_W(10)) bus ();
  fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus2 ();

  fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run16(input logic o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [2:0] fl, output bit bok);
    bit seen;
    seen = 0;
    bok  = 1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.x = a; bus.y = b;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.x = ~a; bus.y = ~b; bus.op = ~o;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else if (!bus.busy) bok = 0;
    end
    if (seen) begin res = bus.result; fl = bus.flags; end
    else begin res = 'x; fl = 'x; end
  endtask

  task automatic test_reset();
    n_chk++;
    if ({bus.busy, bus.done, bus.result, bus.flags} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h fl=%b want all zero",
               bus.busy, bus.done, bus.result, bus.flags);
    end
  endtask

  task automatic test_add();
    logic [15:0] r; logic [2:0] f; bit bok;
    run16(1'b0, 16'h3C00, 16'h4000, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h4200, 3'b000}) begin
      n_fail++; $display("FAIL add_1p2: got %h/%b want 4200/000", r, f);
    end
    n_chk++;
    if (!bok) begin n_fail++; $display("FAIL add_busy: busy dropped before done, want high"); end
    @(negedge clk);
    n_chk++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL add_pulse: done=%b one cycle after done, want 0", bus.done);
    end
  endtask

  task automatic test_sub();
    logic [15:0] r; logic [2:0] f; bit bok;
    run16(1'b1, 16'h3E00, 16'h3C00, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h3800, 3'b000}) begin
      n_fail++; $display("FAIL sub_pos: got %h/%b want 3800/000", r, f);
    end
    run16(1'b1, 16'h3C00, 16'h3E00, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'hB800, 3'b000}) begin
      n_fail++; $display("FAIL sub_neg: got %h/%b want b800/000", r, f);
    end
  endtask

  task automatic test_round();
    logic [15:0] r; logic [2:0] f; bit bok;
    run16(1'b0, 16'h3C00, 16'h1000, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h3C00, 3'b000}) begin
      n_fail++; $display("FAIL round_tie_even: got %h/%b want 3c00/000", r, f);
    end
    run16(1'b0, 16'h3C01, 16'h1000, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h3C02, 3'b000}) begin
      n_fail++; $display("FAIL round_tie_up: got %h/%b want 3c02/000", r, f);
    end
  endtask

  task automatic test_range();
    logic [15:0] r; logic [2:0] f; bit bok;
    run16(1'b0, 16'h7BFF, 16'h7BFF, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h7C00, 3'b010}) begin
      n_fail++; $display("FAIL overflow: got %h/%b want 7c00/010", r, f);
    end
    run16(1'b1, 16'h0600, 16'h0400, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h0000, 3'b001}) begin
      n_fail++; $display("FAIL underflow: got %h/%b want 0000/001", r, f);
    end
  endtask

  task automatic test_specials();
    logic [15:0] r; logic [2:0] f; bit bok;
    run16(1'b1, 16'h7C00, 16'h7C00, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h7E00, 3'b100}) begin
      n_fail++; $display("FAIL inf_minus_inf: got %h/%b want 7e00/100", r, f);
    end
    run16(1'b0, 16'h7E01, 16'h3C00, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h7E00, 3'b000}) begin
      n_fail++; $display("FAIL nan_prop: got %h/%b want 7e00/000", r, f);
    end
    run16(1'b0, 16'h8000, 16'h8000, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h8000, 3'b000}) begin
      n_fail++; $display("FAIL neg_zeros: got %h/%b want 8000/000", r, f);
    end
    run16(1'b1, 16'h4500, 16'h4500, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h0000, 3'b000}) begin
      n_fail++; $display("FAIL x_minus_x: got %h/%b want 0000/000", r, f);
    end
  endtask

  task automatic test_abort();
    logic [15:0] r; logic [2:0] f; bit bok; int dones;
    run16(1'b0, 16'h3C00, 16'h4000, r, f, bok);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.x = 16'h4000; bus.y = 16'h3000;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++;
    if ({bus.busy, bus.done, bus.result, bus.flags} !== 21'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b res=%h fl=%b want all zero",
               bus.busy, bus.done, bus.result, bus.flags);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_chk++;
    if (dones != 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
    end
    run16(1'b0, 16'h3C00, 16'h4000, r, f, bok);
    n_chk++;
    if ({r, f} !== {16'h4200, 3'b000}) begin
      n_fail++; $display("FAIL abort_recover: got %h/%b want 4200/000", r, f);
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] r; bit seen;
    seen = 0;
    r = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.x = 16'h3C00; bus.y = 16'h4000;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.x = 16'h7BFF; bus.y = 16'h7BFF;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1; r = bus.result; end
    end
    n_chk++;
    if (r !== 16'h4200) begin
      n_fail++; $display("FAIL busy_ignore: got %h want 4200", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r1, r2; logic [2:0] f1, f2; bit bok;
    run16(1'b0, 16'h3C00, 16'h3C00, r1, f1, bok);
    run16(1'b1, 16'h4000, 16'h3C00, r2, f2, bok);
    n_chk++;
    if ({r1, f1} !== {16'h4000, 3'b000}) begin
      n_fail++; $display("FAIL b2b_first: got %h/%b want 4000/000", r1, f1);
    end
    n_chk++;
    if ({r2, f2} !== {16'h3C00, 3'b000}) begin
      n_fail++; $display("FAIL b2b_second: got %h/%b want 3c00/000", r2, f2);
    end
  endtask

  task automatic test_wide();
    logic [31:0] r; logic [2:0] f; bit seen;
    seen = 0;
    r = 'x; f = 'x;
    @(negedge clk);
    bus2.start = 1'b1; bus2.op = 1'b0; bus2.x = 32'h3F80_0000; bus2.y = 32'h4000_0000;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus2.done) begin seen = 1; r = bus2.result; f = bus2.flags; end
    end
    n_chk++;
    if ({r, f} !== {32'h4040_0000, 3'b000}) begin
      n_fail++; $display("FAIL sp_add: got %h/%b want 40400000/000", r, f);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    bus.start = 1'b0;  bus.op = 1'b0;  bus.x = '0;  bus.y = '0;
    bus2.start = 1'b0; bus2.op = 1'b0; bus2.x = '0; bus2.y = '0;
    #1;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_add();
    test_sub();
    test_round();
    test_range();
    test_specials();
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor.
- Generalises the fixed 16-bit add/sub engine to any exponent and mantissa width.
- Adds a start/busy/done handshake, guard/round/sticky rounding to nearest-even, and full special-value handling (±0, ±inf, NaN).
- Sits beside the other FPU datapath blocks; one operation is in flight at a time.

Parameters:
- EXP_W, 5, exponent field width (≥3); BIAS = 2^(EXP_W-1)-1.
- MAN_W, 10, stored fraction width (≥2); working significand = 1 hidden + MAN_W + 3 (G,R,S) bits, plus 1 carry bit.
- W = 1+EXP_W+MAN_W (derived, not overridable), total word width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = x+y, 1 = x−y.
- x  in  W  operand A {sign, exp, frac}.
- y  in  W  operand B.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result/flags are valid in that cycle and held until the next accepted start.
- result  out  W  packed result.
- flags  out  3  {invalid, overflow, underflow}; updated with done, held until next start.

Behaviour:
- Reset (async): state = IDLE; busy=0, done=0, result=0, flags=0. Reset mid-operation aborts the operation with no done pulse.
- Operand capture: x, y, op are registered on an accepted start; later input changes are ignored. Start while busy is ignored.
- Subtraction is handled by inverting y's sign at capture.
- Input classes: exp=0 is zero (subnormals flushed, sign kept); exp=all-ones with frac=0 is inf; all-ones with frac≠0 is NaN.
- FSM states:
  - IDLE: on start go to UNPACK.
  - UNPACK: classify operands and swap so A has the larger magnitude (exp, then frac). Then:
    - Any NaN, or inf−inf (opposite effective signs): go to SPECIAL.
    - Any inf or any zero: go to SPECIAL.
    - Otherwise go to ALIGN; d = expA−expB.
  - SPECIAL (one cycle, then DONE):
    - NaN or inf−inf → canonical qNaN {0, all-ones, 1 followed by MAN_W−1 zeros}; inf−inf also sets invalid.
    - inf → that inf.
    - Both zero → sign = signA AND signB.
    - One zero → the other operand (sign as effective).
  - ALIGN: shift B right 1 bit/cycle while d>0, decrementing d; bits shifted out OR into S. If d > MAN_W+3, B collapses in one cycle to sticky-only (S=1 if B≠0).
  - ADD (one cycle): same effective sign → A+B; otherwise A−B (never negative after the swap). Sign = signA. An exact 0 result → +0, go to DONE.
  - NORM:
    - Carry set → shift right 1 (LSB ORs into S), exp+1.
    - Otherwise shift left 1 bit/cycle, exp−1, until the hidden bit = 1.
  - ROUND: RNE on G,R,S (round up if G & (R|S|LSB)). A carry out of rounding renormalises (shift right, exp+1).
  - PACK:
    - exp ≥ all-ones → ±inf, overflow=1.
    - exp ≤ 0 → ±0 (sign kept), underflow=1.
    - Otherwise pack normally.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Exponent arithmetic uses an EXP_W+2-bit signed working register, so the over/underflow checks cannot wrap.
- Latency (start edge to done): specials 3 cycles. Normal path ≤ 6 + min(d, 1) + min(d, MAN_W+3) + (MAN_W+2) cycles; no fixed latency is guaranteed, so the bench must wait on done.
- The next start is accepted in the cycle after done (back-to-back allowed).

Test Plan:
- Default params, op=0, x=0x3C00 (1.0), y=0x4000 (2.0) → result 0x4200, flags 000, one done pulse, busy high throughout.
- op=1, x=0x3E00 (1.5), y=0x3C00 → 0x3800 (0.5). Swapped operands → 0xB800.
- Rounding: 0x3C00+0x1000 → 0x3C00 (tie to even). 0x3C01+0x1000 → 0x3C02.
- Overflow: 0x7BFF+0x7BFF → 0x7C00, flags 010. Underflow: op=1, 0x0600−0x0400 → 0x0000, flags 001.
- Specials:
  - 0x7C00−0x7C00 → 0x7E00, flags 100.
  - 0x7E01+0x3C00 → 0x7E00.
  - 0x8000+0x8000 → 0x8000.
  - x−x with x=0x4500 → 0x0000.
- Control:
  - Reset asserted mid-ALIGN → outputs 0, no done pulse; a following start completes correctly.
  - start pulsed while busy → ignored.
  - Back-to-back starts → two correct done pulses.
  - EXP_W=8, MAN_W=23: 0x3F800000+0x40000000 → 0x40400000.
